// File: rtl/ir_fetch_sequencer.sv
// Two-read instruction fetch: drives memory reads and the PC/IR register controls so that
// one 16-bit instruction is assembled from two byte-wide reads at PC and PC+1.
module ir_fetch_sequencer #(
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] PCValue,
  input  logic [7:0]  MemData,
  input  logic        MemReady,
  output logic [15:0] MemAddress,
  output logic        MemRead,
  output logic        PC_E,
  output logic [2:0]  PC_FunSel,
  output logic        IR_E,
  output logic [2:0]  IR_FunSel,
  output logic [15:0] IR_I,
  output logic        Busy,
  output logic        Done,
  output logic        Timeout
);

  localparam int unsigned   CntW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

  localparam logic [2:0] FsIncrement = 3'b001;
  localparam logic [2:0] FsLoad      = 3'b010;
  localparam logic [2:0] FsClrHiWrLo = 3'b100;
  localparam logic [2:0] FsWrLo      = 3'b101;
  localparam logic [2:0] FsWrHi      = 3'b110;

  typedef enum logic [1:0] {StIdle, StReqFirst, StReqSecond, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    MemAddress = 16'h0000;
    MemRead    = 1'b0;
    PC_E       = 1'b0;
    PC_FunSel  = 3'b000;
    IR_E       = 1'b0;
    IR_FunSel  = 3'b000;
    IR_I       = 16'h0000;
    Busy       = 1'b0;
    Done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (Start) state_d = StReqFirst;
      end
      StReqFirst, StReqSecond: begin
        Busy       = 1'b1;
        MemRead    = 1'b1;
        MemAddress = PCValue;
        // An arriving byte takes priority over an expiring wait limit.
        if (MemReady) begin
          PC_E      = 1'b1;
          PC_FunSel = FsIncrement;
          IR_E      = 1'b1;
          cnt_d     = '0;
          if (state_q == StReqFirst) begin
            state_d = StReqSecond;
            if (BIG_ENDIAN) begin
              IR_FunSel = FsLoad;
              IR_I      = {MemData, 8'h00};
            end else begin
              IR_FunSel = FsClrHiWrLo;
              IR_I      = {8'h00, MemData};
            end
          end else begin
            state_d   = StDone;
            IR_FunSel = BIG_ENDIAN ? FsWrLo : FsWrHi;
            IR_I      = {8'h00, MemData};
          end
        end else if ((TIMEOUT > 0) && (cnt_q == CntLimit)) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Timeout = timeout_q;

endmodule
